// File: rtl/ysyx_22050039_lsu_pkg.sv
// Shared types and encodings for the ysyx_22050039 load/store unit.
package ysyx_22050039_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // in_op = {is_store, is_unsigned, size[1:0]}
    localparam int OP_STORE    = 3;
    localparam int OP_UNSIGNED = 2;
    localparam int OP_SIZE_HI  = 1;
    localparam int OP_SIZE_LO  = 0;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_low_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22050039_lsu_align.sv
// Combinational lane logic: load byte extract/extend and store byte-mask/shift.
module ysyx_22050039_lsu_align
    import ysyx_22050039_lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      lane,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [7:0]      wmask,
    output logic [XLEN-1:0] wdata_shifted
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      base_mask;

    always_comb begin
        shifted       = rdata >> {lane, 3'b000};
        load_data     = '0;
        base_mask     = 8'h00;
        case (size)
            SZ_B: begin
                base_mask = 8'h01;
                load_data = is_unsigned ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                        : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                base_mask = 8'h03;
                load_data = is_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                        : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                base_mask = 8'h0F;
                load_data = is_unsigned ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                        : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            end
            default: begin
                base_mask = 8'hFF;
                load_data = shifted;
            end
        endcase
        wmask         = base_mask << lane;
        wdata_shifted = wdata << {lane, 3'b000};
    end

endmodule

// File: rtl/ysyx_22050039_lsu.sv
// ysyx_22050039 load/store stage: IDLE -> REQ -> WAIT -> DONE memory transaction FSM.
// Optional misaligned-access trap: define YSYX_22050039_LSU_MISALIGN_CHK_EN.
module ysyx_22050039_lsu
    import ysyx_22050039_lsu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RDW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_mem,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [RDW-1:0]  in_rd,
    input  logic            in_rd_wen,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wen,
    output logic [7:0]      mem_wmask,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [RDW-1:0]  out_rd,
    output logic            out_rd_wen,
    output logic            out_err
);

    state_t          state, next_state;
    logic [XLEN-1:0] addr_q, wdata_q, data_q;
    logic [3:0]      op_q;
    logic [RDW-1:0]  rd_q;
    logic            rd_wen_q, err_q;

    logic            misalign_in;
    logic [2:0]      lane;
    logic [XLEN-1:0] load_data, wdata_shifted;
    logic [7:0]      wmask;

    logic [1:0] size_q;
    logic       store_q;
    assign size_q  = op_q[OP_SIZE_HI:OP_SIZE_LO];
    assign store_q = op_q[OP_STORE];

`ifdef YSYX_22050039_LSU_MISALIGN_CHK_EN
    assign misalign_in = in_is_mem && |(in_addr[2:0] & size_low_mask(in_op[OP_SIZE_HI:OP_SIZE_LO]));
    assign lane        = addr_q[2:0];
`else
    assign misalign_in = 1'b0;
    assign lane        = addr_q[2:0] & ~size_low_mask(size_q);
`endif

    ysyx_22050039_lsu_align #(.XLEN(XLEN)) u_align (
        .lane          (lane),
        .size          (size_q),
        .is_unsigned   (op_q[OP_UNSIGNED]),
        .rdata         (mem_rdata),
        .wdata         (wdata_q),
        .load_data     (load_data),
        .wmask         (wmask),
        .wdata_shifted (wdata_shifted)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid) next_state = (!in_is_mem || misalign_in) ? DONE : REQ;
            REQ:  if (mem_req_ready) next_state = WAIT;
            WAIT: if (mem_rsp_valid) next_state = DONE;
            DONE: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: fields are captured only on accept, so request and result stay stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            rd_wen_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (in_valid) begin
                    addr_q   <= in_addr;
                    wdata_q  <= in_wdata;
                    op_q     <= in_op;
                    rd_q     <= in_rd;
                    err_q    <= misalign_in;
                    data_q   <= in_is_mem ? '0 : in_addr;
                    rd_wen_q <= in_rd_wen && !(in_is_mem && (in_op[OP_STORE] || misalign_in));
                end
                WAIT: if (mem_rsp_valid && !store_q) data_q <= load_data;
                default: ;
            endcase
        end
    end

    // Store-side fields are zeroed outside an active store request.
    assign in_ready      = (state == IDLE);
    assign mem_req_valid = (state == REQ);
    assign mem_addr      = {addr_q[XLEN-1:3], 3'b000};
    assign mem_wen       = mem_req_valid && store_q;
    assign mem_wmask     = mem_wen ? wmask : 8'h00;
    assign mem_wdata     = mem_wen ? wdata_shifted : '0;
    assign out_valid     = (state == DONE);
    assign out_data      = data_q;
    assign out_rd        = rd_q;
    assign out_rd_wen    = out_valid && rd_wen_q;
    assign out_err       = out_valid && err_q;

endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// Directed self-checking bench for ysyx_22050039_lsu (macro-aware misalign test).
module tb_ysyx_22050039_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_is_mem, in_rd_wen;
    logic [3:0]  in_op;
    logic [63:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        out_valid, out_ready, out_rd_wen, out_err;
    logic [63:0] out_data;
    logic [4:0]  out_rd;

    int total = 0;
    int bad   = 0;

    ysyx_22050039_lsu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_mem(in_is_mem), .in_op(in_op),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic is_mem, input logic [3:0] op, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [4:0] rd, input logic rd_wen);
        in_valid = 1'b1; in_is_mem = is_mem; in_op = op; in_addr = addr;
        in_wdata = wdata; in_rd = rd; in_rd_wen = rd_wen;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_is_mem = 1'b0; in_op = 4'h0; in_addr = '0; in_wdata = '0;
        in_rd = '0; in_rd_wen = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rdata = '0;
        out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_req_valid got=%b exp=0", mem_req_valid); end
        total++; if ({out_rd_wen, out_err, mem_wen} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {out_rd_wen, out_err, mem_wen}); end
        total++; if ({out_data, mem_addr, mem_wdata} !== '0) begin bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", out_data, mem_addr, mem_wdata); end
        total++; if (mem_wmask !== 8'h00) begin bad++; $display("FAIL reset_wmask got=%h exp=00", mem_wmask); end
    endtask

    task automatic test_pass_through();
        out_ready = 1'b1;
        drive_in(1'b0, 4'h0, 64'h1234, 64'h0, 5'd5, 1'b1);
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pt_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 64'h1234) begin bad++; $display("FAIL pt_data got=%h exp=1234", out_data); end
        total++; if (out_rd !== 5'd5 || out_rd_wen !== 1'b1) begin bad++; $display("FAIL pt_rd got=%0d/%b exp=5/1", out_rd, out_rd_wen); end
        total++; if (mem_req_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL pt_hs got=%b/%b exp=0/0", mem_req_valid, in_ready); end
        tick();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL pt_exit got=%b/%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_load(input string name, input logic [3:0] op, input logic [63:0] addr,
                             input logic [63:0] rdata, input logic [63:0] exp);
        mem_req_ready = 1'b1; out_ready = 1'b1;
        drive_in(1'b1, op, addr, 64'h0, 5'd3, 1'b1);
        tick();
        in_valid = 1'b0;
        total++; if (mem_req_valid !== 1'b1 || mem_wen !== 1'b0) begin bad++; $display("FAIL %s req got=%b/%b exp=1/0", name, mem_req_valid, mem_wen); end
        total++; if (mem_addr !== {addr[63:3], 3'b000}) begin bad++; $display("FAIL %s addr got=%h exp=%h", name, mem_addr, {addr[63:3], 3'b000}); end
        tick();
        mem_rsp_valid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rsp_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s valid got=%b exp=1", name, out_valid); end
        total++; if (out_data !== exp) begin bad++; $display("FAIL %s data got=%h exp=%h", name, out_data, exp); end
        total++; if (out_rd !== 5'd3 || out_rd_wen !== 1'b1) begin bad++; $display("FAIL %s rd got=%0d/%b exp=3/1", name, out_rd, out_rd_wen); end
        tick();
    endtask

    task automatic test_store();
        mem_req_ready = 1'b1; out_ready = 1'b1;
        drive_in(1'b1, 4'b1001, 64'h8000_0006, 64'hABCD, 5'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        total++; if (mem_req_valid !== 1'b1 || mem_wen !== 1'b1) begin bad++; $display("FAIL sh_req got=%b/%b exp=1/1", mem_req_valid, mem_wen); end
        total++; if (mem_wmask !== 8'hC0) begin bad++; $display("FAIL sh_wmask got=%h exp=c0", mem_wmask); end
        total++; if (mem_wdata !== 64'hABCD_0000_0000_0000) begin bad++; $display("FAIL sh_wdata got=%h exp=abcd000000000000", mem_wdata); end
        total++; if (mem_addr !== 64'h8000_0000) begin bad++; $display("FAIL sh_addr got=%h exp=80000000", mem_addr); end
        tick();
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_rd_wen !== 1'b0) begin bad++; $display("FAIL sh_done got=%b/%b exp=1/0", out_valid, out_rd_wen); end
        tick();
        // SB at lane 1 and SD at lane 0 cover the other mask widths.
        drive_in(1'b1, 4'b1000, 64'h8000_0001, 64'h5A, 5'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        total++; if (mem_wmask !== 8'h02 || mem_wdata !== 64'h5A00) begin bad++; $display("FAIL sb_lane got=%h/%h exp=02/5a00", mem_wmask, mem_wdata); end
        tick(); mem_rsp_valid = 1'b1; tick(); mem_rsp_valid = 1'b0; tick();
        drive_in(1'b1, 4'b1011, 64'h8000_0008, 64'h0102_0304_0506_0708, 5'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        total++; if (mem_wmask !== 8'hFF || mem_wdata !== 64'h0102_0304_0506_0708) begin bad++; $display("FAIL sd_lane got=%h/%h exp=ff/0102030405060708", mem_wmask, mem_wdata); end
        tick(); mem_rsp_valid = 1'b1; tick(); mem_rsp_valid = 1'b0; tick();
    endtask

    task automatic test_stalls();
        mem_req_ready = 1'b0; out_ready = 1'b1;
        drive_in(1'b1, 4'b0010, 64'h8000_0010, 64'h0, 5'd7, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (mem_req_valid !== 1'b1 || mem_addr !== 64'h8000_0010 || in_ready !== 1'b0) begin bad++; $display("FAIL stall_req%0d got=%b/%h/%b exp=1/80000010/0", i, mem_req_valid, mem_addr, in_ready); end
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++; if (mem_req_valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL stall_wait%0d got=%b/%b/%b exp=0/0/0", i, mem_req_valid, out_valid, in_ready); end
            tick();
        end
        mem_rsp_valid = 1'b1; mem_rdata = 64'h0000_0000_8000_0001; out_ready = 1'b0;
        tick();
        mem_rsp_valid = 1'b0; mem_rdata = 64'h0;
        for (int i = 0; i < 2; i++) begin
            total++; if (out_valid !== 1'b1 || out_data !== 64'hFFFF_FFFF_8000_0001 || out_rd !== 5'd7 || in_ready !== 1'b0) begin bad++; $display("FAIL stall_out%0d got=%b/%h/%0d/%b exp=1/ffffffff80000001/7/0", i, out_valid, out_data, out_rd, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_hold got=%b exp=1", out_valid); end
        tick();
        mem_req_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL stall_single%0d got=%b/%b exp=0/1", i, out_valid, in_ready); end
            tick();
        end
    endtask

    task automatic test_reset_mid_op();
        mem_req_ready = 1'b1; out_ready = 1'b1;
        drive_in(1'b1, 4'b0011, 64'h8000_0008, 64'h0, 5'd2, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b/%b exp=1/0", in_ready, out_valid); end
        mem_rsp_valid = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_0001;
        tick();
        mem_rsp_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL rstmid_rsp got=%b/%b/%b exp=0/1/0", out_valid, in_ready, mem_req_valid); end
        tick();
        total++; if (out_valid !== 1'b0 || out_data !== 64'h0) begin bad++; $display("FAIL rstmid_after got=%b/%h exp=0/0", out_valid, out_data); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive_in(1'b0, 4'h0, 64'hAAAA, 64'h0, 5'd1, 1'b1);
        tick();
        drive_in(1'b0, 4'h0, 64'hBBBB, 64'h0, 5'd2, 1'b1);
        total++; if (in_ready !== 1'b0 || out_data !== 64'hAAAA) begin bad++; $display("FAIL b2b_first got=%b/%h exp=0/aaaa", in_ready, out_data); end
        tick();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b/%b exp=1/0", in_ready, out_valid); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 64'hBBBB || out_rd !== 5'd2) begin bad++; $display("FAIL b2b_second got=%b/%h/%0d exp=1/bbbb/2", out_valid, out_data, out_rd); end
        tick();
    endtask

    task automatic test_misalign();
        mem_req_ready = 1'b1; out_ready = 1'b1;
        drive_in(1'b1, 4'b0010, 64'h8000_0002, 64'h0, 5'd9, 1'b1);
        tick();
        in_valid = 1'b0;
`ifdef YSYX_22050039_LSU_MISALIGN_CHK_EN
        total++; if (mem_req_valid !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL mis_skip got=%b/%b exp=0/1", mem_req_valid, out_valid); end
        total++; if (out_err !== 1'b1 || out_rd_wen !== 1'b0) begin bad++; $display("FAIL mis_err got=%b/%b exp=1/0", out_err, out_rd_wen); end
        tick();
        total++; if (out_err !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b/%b exp=0/0", out_err, out_valid); end
`else
        total++; if (mem_req_valid !== 1'b1 || mem_addr !== 64'h8000_0000) begin bad++; $display("FAIL mis_req got=%b/%h exp=1/80000000", mem_req_valid, mem_addr); end
        tick();
        mem_rsp_valid = 1'b1; mem_rdata = 64'h1122_3344_5566_7788;
        tick();
        mem_rsp_valid = 1'b0;
        total++; if (out_data !== 64'h5566_7788 || out_err !== 1'b0 || out_rd_wen !== 1'b1) begin bad++; $display("FAIL mis_align got=%h/%b/%b exp=55667788/0/1", out_data, out_err, out_rd_wen); end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load("lb",  4'b0000, 64'h8000_0003, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80);
        test_load("lbu", 4'b0100, 64'h8000_0003, 64'h0000_0000_80FF_0000, 64'h0000_0000_0000_0080);
        test_load("lh",  4'b0001, 64'h8000_0004, 64'h0000_9ABC_0000_0000, 64'hFFFF_FFFF_FFFF_9ABC);
        test_load("lhu", 4'b0101, 64'h8000_0004, 64'h0000_9ABC_0000_0000, 64'h0000_0000_0000_9ABC);
        test_load("lw",  4'b0010, 64'h8000_0004, 64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF);
        test_load("lwu", 4'b0110, 64'h8000_0004, 64'h89AB_CDEF_0000_0000, 64'h0000_0000_89AB_CDEF);
        test_load("ld",  4'b0011, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        test_store();
        test_stalls();
        test_reset_mid_op();
        test_back_to_back();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ysyx_22050039_lsu.md
Name: ysyx_22050039_lsu

Overview:
- Load/store stage directly downstream of the execute unit in the ysyx_22050039 RV64 core.
- Consumes the execute result as an effective address, or as a pass-through value for non-memory instructions, plus the store data and the decoded memory op.
- Runs a valid/ready transaction on an 8-byte data-memory port and aligns and extends load data.
- Hands the result to writeback over a valid/ready interface.

Parameters:
- XLEN, 64, datapath and address width; only 64 is supported.
- RDW, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  execute result available
- in_ready  out  1  LSU can accept
- in_is_mem  in  1  1 = load/store, 0 = pass-through
- in_op  in  4  {is_store, is_unsigned, size[1:0]}; size 0=B, 1=H, 2=W, 3=D
- in_addr  in  XLEN  effective address, or the result for pass-through ops
- in_wdata  in  XLEN  store data, right-aligned
- in_rd  in  RDW  destination register
- in_rd_wen  in  1  writes rd
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  XLEN  in_addr with bits [2:0] cleared
- mem_wen  out  1  store
- mem_wmask  out  8  byte enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_rsp_valid  in  1  response (load data or store ack)
- mem_rdata  in  XLEN  raw 8-byte word
- out_valid  out  1  result to writeback
- out_ready  in  1  writeback accepts
- out_data  out  XLEN  result
- out_rd  out  RDW  destination
- out_rd_wen  out  1  register write enable
- out_err  out  1  misaligned-access flag

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous, active-high.
- Reset state:
  - State = IDLE.
  - All out/mem valids, out_rd_wen and out_err = 0.
  - in_ready = 1 in the first cycle after reset.
  - Data outputs = 0.
- FSM states: IDLE, REQ, WAIT, DONE. in_ready = (state == IDLE).
- IDLE:
  - On in_valid, latch all inputs.
  - in_is_mem = 0: go to DONE; out_data = in_addr.
  - in_is_mem = 1: go to REQ.
- REQ:
  - mem_req_valid = 1; mem_addr, mem_wen, mem_wmask and mem_wdata stay stable until mem_req_ready.
  - On handshake, go to WAIT. Minimum latency is one cycle in REQ.
- WAIT:
  - On mem_rsp_valid, go to DONE.
  - Loads: lane = addr[2:0]; select size bytes from mem_rdata >> (lane*8); sign-extend if is_unsigned = 0, else zero-extend.
  - Stores: out_rd_wen = 0.
- DONE:
  - out_valid = 1 and outputs stay stable until out_ready, then go to IDLE.
  - Next input is accepted the cycle after DONE exits; no bypass.
- Store encoding:
  - mem_wmask = ((1 << (1 << size)) - 1) << addr[2:0].
  - mem_wdata = in_wdata << (addr[2:0]*8).
- Latency:
  - Pass-through: 2 cycles from accept to out_valid deasserting, with out_ready held at 1.
  - Memory op: 3 cycles plus memory stalls.
- Unexpected inputs: mem_rsp_valid outside WAIT and mem_req_ready outside REQ are ignored.
- Reset mid-operation: any state returns to IDLE. A pending response is dropped, and a later response is ignored.

Optional Feature:
- Macro: YSYX_22050039_LSU_MISALIGN_CHK_EN.
- Defined: an access with addr not aligned to its size skips memory and goes IDLE -> DONE with out_err = 1 and out_rd_wen = 0. out_err clears on leaving DONE.
- Undefined: the address is force-aligned (low size bits cleared) before lane selection, and out_err is tied to 0.

Decomposition:
- Package ysyx_22050039_lsu_pkg holds:
  - the state enum;
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - the in_op bit-field positions.
- Sub-module ysyx_22050039_lsu_align: combinational load extract/extend and store mask/shift, so it can be unit-tested in isolation.

Test Plan:
- Pass-through: in_is_mem = 0, in_addr = 0x1234, rd = 5 -> out_valid 1 cycle after accept; out_data = 0x1234, out_rd = 5, no mem_req_valid.
- Signed byte load: addr 0x80000003, op LB, mem_rdata = 0x00000000_80FF0000_ | lane3 = 0x80 -> out_data = 0xFFFFFFFFFFFFFF80; LBU gives 0x80.
- Store: SH at addr 0x80000006, wdata = 0xABCD -> mem_wmask = 0xC0, mem_wdata = 0xABCD000000000000, out_rd_wen = 0.
- Stalls: mem_req_ready low for 3 cycles, then rsp 2 cycles later; out_ready low for 2 cycles -> request and output fields stay stable; in_ready = 0 throughout; single completion.
- Reset mid-op: assert rst in WAIT, then deliver mem_rsp_valid -> no out_valid; in_ready = 1 the next cycle.
- Misalign (macro on): LW at 0x80000002 -> no mem_req_valid; out_err = 1, out_rd_wen = 0. Macro off: access goes to 0x80000000, lanes 0-3.
